// File: rtl/pe_psum_drain.sv
// pe_psum_drain
//
// Consumer end of the PE array's psum_t_down interface. The bottom-row partial
// sums arrive column-skewed: column c of a wave shows up c*SKEW cycles after
// column 0. Each column is delayed so that all N words of a wave line up on the
// cycle column N-1 arrives. That aligned row is pushed into a DEPTH-row FIFO.
// A serializer then streams the head row column-by-column on a valid/ready
// interface. Words are passed bit-exact.
//
// Ports
//   i_clk         clock, rising edge
//   i_rest_n      synchronous active-low reset (priority over i_clr)
//   i_clr         synchronous flush, same effect as reset
//   i_col0_valid  column 0 of a wave is present on psum_f_top[0] this cycle
//   psum_f_top    bottom-row psums, one word per column (column-skewed)
//   o_psum        serialized word (0 while idle)
//   o_valid       o_psum is valid
//   i_ready       downstream accepts o_psum this cycle
//   o_col_idx     column index of o_psum
//   o_last        o_psum is the last column of its row
//   o_count       rows currently held in the FIFO
//   o_overflow    sticky: a committed row was dropped because the FIFO was full
//
// NUMBER_PE_COL >= 2 and DEPTH a power of two >= 2 are assumed; SKEW >= 1.

module pe_psum_drain #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUMBER_PE_COL = 8,
    parameter int unsigned SKEW          = 1,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rest_n,
    input  logic                               i_clr,
    input  logic                               i_col0_valid,
    input  logic [DATA_WIDTH-1:0]              psum_f_top [NUMBER_PE_COL-1:0],
    output logic [DATA_WIDTH-1:0]              o_psum,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [$clog2(NUMBER_PE_COL)-1:0]   o_col_idx,
    output logic                               o_last,
    output logic [$clog2(DEPTH+1)-1:0]         o_count,
    output logic                               o_overflow
);

    localparam int unsigned ChainLen = (NUMBER_PE_COL - 1) * SKEW;
    localparam int unsigned ColW     = $clog2(NUMBER_PE_COL);
    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam int unsigned CntW     = $clog2(DEPTH + 1);

    localparam logic [ColW-1:0] LastCol  = ColW'(NUMBER_PE_COL - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    typedef logic [NUMBER_PE_COL-1:0][DATA_WIDTH-1:0] row_t;

    logic                w_commit;
    row_t                w_row;

    row_t                r_mem [DEPTH];
    logic [PtrW-1:0]     r_wptr, w_wptr_d;
    logic [PtrW-1:0]     r_rptr, w_rptr_d;
    logic [CntW-1:0]     r_count, w_count_d;
    logic [ColW-1:0]     r_col_idx, w_col_idx_d;
    logic                r_overflow, w_overflow_d;
    state_e              r_state, w_state_d;

    logic                w_full;
    logic                w_xfer;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // ------------------------------------------------------------------
    // Valid chain: a wave's column-0 strobe emerges exactly when its last
    // column is on the input, which is the row commit point.
    // ------------------------------------------------------------------
    generate
        if (ChainLen == 0) begin : g_no_chain
            assign w_commit = i_col0_valid;
        end else begin : g_chain
            logic [ChainLen-1:0] r_vchain;

            always_ff @(posedge i_clk) begin
                if (!i_rest_n || i_clr) begin
                    r_vchain <= '0;
                end else begin
                    // Shift left, new strobe enters at bit 0.
                    r_vchain <= ChainLen'({r_vchain, i_col0_valid});
                end
            end

            assign w_commit = r_vchain[ChainLen-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Deskew: column c is delayed (N-1-c)*SKEW cycles so every column of a
    // wave lands in w_row on the commit cycle. Data is free-running and
    // never reset; only the valid chain decides what gets committed.
    // ------------------------------------------------------------------
    generate
        for (genvar gc = 0; gc < NUMBER_PE_COL; gc++) begin : g_col
            localparam int unsigned Dly = (NUMBER_PE_COL - 1 - gc) * SKEW;

            if (Dly == 0) begin : g_direct
                assign w_row[gc] = psum_f_top[gc];
            end else begin : g_delay
                logic [Dly-1:0][DATA_WIDTH-1:0] r_line;

                always_ff @(posedge i_clk) begin
                    r_line <= (Dly * DATA_WIDTH)'({r_line, psum_f_top[gc]});
                end

                assign w_row[gc] = r_line[Dly-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO control. A commit into a full FIFO still succeeds when the head
    // row is popped on the same edge; otherwise the row is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_full = (r_count == DepthCnt);
        w_xfer = (r_state == StSend) && i_ready;
        w_pop  = w_xfer && (r_col_idx == LastCol);
        w_push = w_commit && (!w_full || w_pop);
        w_drop = w_commit && w_full && !w_pop;
    end

    always_comb begin
        w_wptr_d     = r_wptr;
        w_rptr_d     = r_rptr;
        w_count_d    = r_count;
        w_col_idx_d  = r_col_idx;
        w_overflow_d = r_overflow | w_drop;

        if (w_push) begin
            w_wptr_d = r_wptr + PtrW'(1);
        end
        if (w_pop) begin
            w_rptr_d = r_rptr + PtrW'(1);
        end

        if (w_push && !w_pop) begin
            w_count_d = r_count + CntW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - CntW'(1);
        end

        if (w_xfer) begin
            w_col_idx_d = w_pop ? '0 : r_col_idx + ColW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_row;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rest_n || i_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_col_idx  <= '0;
            r_overflow <= 1'b0;
            r_state    <= StIdle;
        end else begin
            r_wptr     <= w_wptr_d;
            r_rptr     <= w_rptr_d;
            r_count    <= w_count_d;
            r_col_idx  <= w_col_idx_d;
            r_overflow <= w_overflow_d;
            r_state    <= w_state_d;
        end
    end

    // State tracks FIFO occupancy after this edge, so o_valid rises the cycle
    // after the first commit into an empty FIFO.
    always_comb begin
        w_state_d = r_state;
        o_valid   = 1'b0;
        o_psum    = '0;

        unique case (r_state)
            StIdle: begin
                if (w_count_d != '0) begin
                    w_state_d = StSend;
                end
            end
            StSend: begin
                o_valid = 1'b1;
                o_psum  = r_mem[r_rptr][r_col_idx];
                if (w_count_d == '0) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_col_idx  = r_col_idx;
    assign o_last     = o_valid && (r_col_idx == LastCol);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: doc/pe_psum_drain.md
# pe_psum_drain

Receives the bottom-row partial sums leaving the FP32 PE array (one word per column, column-skewed) and deskews each wave into an aligned row. Buffers up to DEPTH rows and serializes them column-by-column onto a valid/ready stream toward the output SRAM writer. It is the consumer end of the array's `psum_t_down` interface. Values are passed bit-exact; no arithmetic is applied to them.

## Interface
- `DATA_WIDTH`, 32: width of one FP32 psum word.
- `NUMBER_PE_COL`, 8: number of PE columns, which is also the number of words per row.
- `SKEW`, 1: cycles between column c and column c+1 outputs of the same wave. Must be ≥1.
- `DEPTH`, 4: row FIFO depth. Must be a power of two, ≥2.

- `i_clk` in 1: clock. All logic is on the rising edge.
- `i_rest_n` in 1: reset, synchronous, active-low.
- `i_clr` in 1: synchronous flush with the same effect as reset. Reset has priority.
- `i_col0_valid` in 1: column 0 of a wave is valid this cycle. Column c of the same wave is valid exactly c*SKEW cycles later.
- `psum_f_top` in `DATA_WIDTH` × [`NUMBER_PE_COL`-1:0] (unpacked): array bottom-row psums.
- `o_psum` out `DATA_WIDTH`: serialized psum word.
- `o_valid` out 1: `o_psum` is valid.
- `i_ready` in 1: downstream accepts the word.
- `o_col_idx` out $clog2(`NUMBER_PE_COL`): column index of `o_psum`.
- `o_last` out 1: `o_psum` is the last column of its row.
- `o_count` out $clog2(`DEPTH`+1): number of rows held in the FIFO.
- `o_overflow` out 1: sticky flag; a row was dropped.

## Operation
- **Valid delay chain.** `i_col0_valid` is shifted through a chain (N-1)*SKEW stages long, where N = `NUMBER_PE_COL`. The chain output `commit` is high exactly at the edge where column N-1 of that wave is sampled.
- **Deskew.** Column c passes through a register delay line of length (N-1-c)*SKEW. Column N-1 has zero delay. At `commit`, all N delayed words belong to the same wave.
- **Row FIFO.** At a `commit` edge, the N aligned words are written as one row entry.
  - Push while full with no pop that edge: row dropped, `o_overflow` set, FIFO unchanged.
  - Push and pop on the same edge while full: both performed, `o_count` stays `DEPTH`, no overflow.
- **Serializer.** It uses two states.
  - IDLE (FIFO empty): `o_valid`=0 and `o_psum`=0.
  - SEND (FIFO non-empty): `o_valid`=1 and `o_psum` = head[`o_col_idx`].
  - On `o_valid`&&`i_ready`, `o_col_idx` increments.
  - At `o_col_idx`=N-1 the transfer pops the head row and wraps `o_col_idx` to 0. The state returns to IDLE if the FIFO is then empty.
- **Stall.** `o_psum`, `o_col_idx` and `o_last` hold while `i_ready`=0.
- `o_last` = `o_valid` && (`o_col_idx`==N-1).
- Waves may arrive on consecutive cycles. Delay lines run freely and are not gated by FIFO state.
- **Reset / `i_clr`.** Clears the valid chain (in-flight waves are never committed), the FIFO pointers, `o_col_idx`, and `o_overflow`. Delay-line data does not need clearing.
- **Reset values:** `o_psum`=0, `o_valid`=0, `o_col_idx`=0, `o_last`=0, `o_count`=0, `o_overflow`=0.

## Timing
- `i_col0_valid` is sampled at edge t0, so the commit edge is t0+(N-1)*SKEW. With defaults, commit is t0+7.
- `o_valid` is high in the cycle after the commit edge when the FIFO was empty. The first word therefore transfers at edge t0+(N-1)*SKEW+1 at the earliest.
- One word transfers per cycle at most. A row occupies N cycles of output bandwidth, so sustained waves faster than one per N cycles eventually fill the FIFO.
- `o_count` updates on the push/pop edge: +1, -1, or unchanged when both happen.
- `o_overflow` rises on the edge of the dropped push and stays high until reset or `i_clr`.

## Test plan
Defaults throughout (N=8, SKEW=1, DEPTH=4).
- **Single wave.** Column c = 0x3F800000+c, column 0 valid at edge 10, `i_ready`=1. Required: `o_valid` high after edge 17; 8 words emitted in order on edges 18–25; `o_col_idx` 0..7; `o_last` only on 0x3F800007; `o_count` 1→0.
- **Back-to-back waves.** 4 waves on consecutive cycles, word = {r[15:0], c[15:0]}, `i_ready`=1. Required: 32 words emitted strictly row-major; `o_overflow`=0; `o_count` peaks at 4 or below.
- **Backpressure overflow.** `i_ready`=0, 5 waves. Required: `o_count`=4; `o_overflow`=1 after the 5th commit. Then `i_ready`=1: rows 0–3 emitted intact and row 4 absent.
- **Mid-row stall.** `i_ready` pattern 1,0,0,1,1 during a row. Required: `o_psum` and `o_col_idx` hold for two cycles; no word repeated or skipped.
- **Full with simultaneous push/pop.** FIFO at 4 rows, serializer on column 7 with `i_ready`=1 at a commit edge. Required: `o_count` stays 4; `o_overflow`=0.
- **Reset mid-flight.** `i_rest_n`=0 for 1 cycle at t0+3 of a wave. Required: no commit occurs; all outputs at reset values; a wave issued afterwards drains normally.
